// File: rtl/axis_sample_packer_if.sv
// AXI4-Stream bus bundle for the sample packer output.
// The packer drives the master modport; a consumer or testbench uses slave.
interface axis_sample_packer_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_sample_packer.sv
// axis_sample_packer: packs pairs of decimated ADC samples into 32-bit
// AXI4-Stream words, buffers them in a 2-entry FIFO, and frames packets
// of a programmable word count with TLAST on the final word.
// Optional build macro PACKER_HEADER_EN prefixes each packet with a
// header word {16'hA5A5, seq}.
module axis_sample_packer #(
    parameter int DATA_IN_WIDTH      = 12,
    parameter int DATA_REG_WIDTH     = 32,
    parameter int C_AXIS_TDATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [DATA_REG_WIDTH-1:0] packet_len_reg,
    input  logic [DATA_IN_WIDTH-1:0]  in_data,
    input  logic                      in_data_valid,
    output logic                      in_data_ready,
    axis_sample_packer_if.master      m_axis,
    output logic                      overflow,
    input  logic                      overflow_clr
);

    typedef enum logic {IDLE, RUN} state_t;
    typedef logic [C_AXIS_TDATA_WIDTH-1:0] word_t;
    typedef logic [DATA_REG_WIDTH-1:0]     len_t;

    state_t      state_q, state_d;
    logic        pending_q;
    logic [15:0] low_q;
    len_t        word_cnt_q, len_q, len_sel;
    logic        ready_q;
    logic        overflow_q;

    // FIFO entries hold {tlast, tdata}
    logic [C_AXIS_TDATA_WIDTH:0] fifo_mem [2];
    logic                        wr_ptr_q, rd_ptr_q;
    logic [1:0]                  fifo_cnt_q, fifo_cnt_d, cnt_after_pop;

    logic  tvalid_q, tlast_q;
    word_t tdata_q;

`ifdef PACKER_HEADER_EN
    logic [15:0] seq_q;
`endif

    logic                        accept, data_push, hdr_push, push, pop;
    logic                        ovf_set, pkt_last;
    logic [C_AXIS_TDATA_WIDTH:0] push_entry;
    logic [15:0]                 sample_ext;

    assign sample_ext    = 16'(in_data);
    assign len_sel       = (packet_len_reg == '0) ? len_t'(1) : packet_len_reg;
    assign pop           = tvalid_q && m_axis.tready;
    assign fifo_cnt_d    = fifo_cnt_q + 2'(push) - 2'(pop);
    assign cnt_after_pop = fifo_cnt_q - 2'(pop);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: start on enable, stop only at a packet boundary
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (data_push && pkt_last && !enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-cycle controls: acceptance, drops, FIFO push word selection
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        accept     = 1'b0;
        ovf_set    = 1'b0;
        hdr_push   = 1'b0;
        push_entry = '0;
        if (state_q == RUN) begin
            accept  = in_data_valid && ready_q;
            ovf_set = in_data_valid && !ready_q;
        end
        data_push = accept && pending_q;
        pkt_last  = (word_cnt_q == len_q - len_t'(1));
`ifdef PACKER_HEADER_EN
        // First sample of a packet: nothing pending and no data word pushed yet
        hdr_push = accept && !pending_q && (word_cnt_q == '0);
        if (hdr_push) push_entry = {1'b0, 16'hA5A5, seq_q};
        else          push_entry = {pkt_last, sample_ext, low_q};
`else
        push_entry = {pkt_last, sample_ext, low_q};
`endif
        push = data_push || hdr_push;
    end

    // Sample pairing, packet framing, ready and overflow flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q  <= 1'b0;
            low_q      <= '0;
            word_cnt_q <= '0;
            len_q      <= len_t'(1);
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (state_q == IDLE && enable) begin
                len_q      <= len_sel;
                word_cnt_q <= '0;
            end
            if (accept) begin
                pending_q <= !pending_q;
                if (!pending_q) low_q <= sample_ext;
            end
            if (data_push) begin
                if (pkt_last) begin
                    word_cnt_q <= '0;
                    if (enable) len_q <= len_sel;
                end else begin
                    word_cnt_q <= word_cnt_q + len_t'(1);
                end
            end
            // Accepting only while a slot is free guarantees every push fits
            ready_q <= (state_d == RUN) && (fifo_cnt_d != 2'd2);
            if (ovf_set)           overflow_q <= 1'b1;
            else if (overflow_clr) overflow_q <= 1'b0;
        end
    end

`ifdef PACKER_HEADER_EN
    // Packet sequence number, advanced after each completed packet
    always_ff @(posedge clk) begin
        if (!rst_n)                     seq_q <= '0;
        else if (data_push && pkt_last) seq_q <= seq_q + 16'd1;
    end
`endif

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= !wr_ptr_q;
            if (pop)  rd_ptr_q <= !rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; validity is tracked by the reset pointers and count.
        if (push) fifo_mem[wr_ptr_q] <= push_entry;
    end

    // Registered AXIS output view of the FIFO head (after this cycle's pop)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
        end else begin
            tvalid_q <= (cnt_after_pop != 2'd0);
            if (cnt_after_pop != 2'd0)
                {tlast_q, tdata_q} <= fifo_mem[pop ? !rd_ptr_q : rd_ptr_q];
        end
    end

    assign in_data_ready = ready_q;
    assign overflow      = overflow_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

endmodule

// File: tb/tb_axis_sample_packer.sv
// Directed self-checking bench for axis_sample_packer with a scoreboard
// queue filled by a packing model and drained by an output monitor.
// Build with PACKER_HEADER_EN defined to exercise the header variant.
module tb_axis_sample_packer;

`ifdef PACKER_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int NACC = HDR ? 2 : 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] packet_len_reg;
    logic [11:0] in_data;
    logic        in_data_valid;
    logic        in_data_ready;
    logic        overflow;
    logic        overflow_clr;

    axis_sample_packer_if #(.DATA_W(32)) axis ();

    axis_sample_packer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .packet_len_reg (packet_len_reg),
        .in_data        (in_data),
        .in_data_valid  (in_data_valid),
        .in_data_ready  (in_data_ready),
        .m_axis         (axis),
        .overflow       (overflow),
        .overflow_clr   (overflow_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entries are {tlast, tdata}
    logic [32:0] exp_q [$];

    // Packing model state
    logic        m_pending;
    logic [15:0] m_low;
    int unsigned m_cnt;
    int unsigned m_len;
    logic [15:0] m_seq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pending = 1'b0;
        m_low     = '0;
        m_cnt     = 0;
        m_len     = 1;
        m_seq     = '0;
    endtask

    task automatic model_start();
        m_len = (packet_len_reg == 0) ? 1 : packet_len_reg;
        m_cnt = 0;
    endtask

    task automatic model_accept(input logic [11:0] s);
        logic last;
        if (!m_pending) begin
            if (HDR && m_cnt == 0) exp_q.push_back({1'b0, 16'hA5A5, m_seq});
            m_low     = 16'(s);
            m_pending = 1'b1;
        end else begin
            last = (m_cnt == m_len - 1);
            exp_q.push_back({last, 4'h0, s, m_low});
            m_pending = 1'b0;
            if (last) begin
                m_cnt = 0;
                m_seq = m_seq + 16'd1;
                if (enable) m_len = (packet_len_reg == 0) ? 1 : packet_len_reg;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic send_acc(input logic [11:0] s);
        in_data       = s;
        in_data_valid = 1'b1;
        check("ready_for_sample", 64'(in_data_ready), 64'(1));
        model_accept(s);
        tick();
    endtask

    task automatic send_drop(input logic [11:0] s);
        in_data       = s;
        in_data_valid = 1'b1;
        check("ready_low_for_drop", 64'(in_data_ready), 64'(0));
        tick();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'(0));
        repeat (2) tick();
    endtask

    // Output monitor: transfers are sampled mid-cycle, away from the edge
    always @(negedge clk) begin
        if (rst_n && axis.tvalid && axis.tready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL spurious_word: observed %0h expected no word", axis.tdata);
            end else begin
                check("word_data", 64'(axis.tdata), 64'(exp_q[0][31:0]));
                check("word_last", 64'(axis.tlast), 64'(exp_q[0][32]));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b0;
        packet_len_reg = 32'd2;
        in_data        = '0;
        in_data_valid  = 1'b0;
        overflow_clr   = 1'b0;
        axis.tready    = 1'b1;
        model_reset();

        // Reset values
        repeat (2) tick();
        check("rst_ready",    64'(in_data_ready), 64'(0));
        check("rst_tvalid",   64'(axis.tvalid),   64'(0));
        check("rst_tlast",    64'(axis.tlast),    64'(0));
        check("rst_tdata",    64'(axis.tdata),    64'(0));
        check("rst_overflow", 64'(overflow),      64'(0));
        rst_n = 1'b1;
        tick();

        // Basic packing, len=2, with output latency checks
        enable = 1'b1;
        tick();
        model_start();
        send_acc(12'h001);
        send_acc(12'h002);
        check("latency_edge_n", 64'(axis.tvalid), 64'(HDR));
        packet_len_reg = 32'd0;             // mid-packet change, applies at boundary
        send_acc(12'h003);
        check("latency_edge_n1", 64'(axis.tvalid), 64'(1));
        send_acc(12'h004);
        in_data_valid = 1'b0;
        check("basic_overflow", 64'(overflow), 64'(0));
        drain();

        // len=0 behaves as a single-word packet
        send_acc(12'hABC);
        packet_len_reg = 32'd2;
        send_acc(12'h123);
        in_data_valid = 1'b0;
        drain();

        // Back-pressure: FIFO fills, ready drops, samples are lost
        packet_len_reg = 32'd3;
        axis.tready    = 1'b0;
        for (int i = 0; i < NACC; i++) send_acc(12'(12'h100 + i));
        send_drop(12'h1F0);
        send_drop(12'h1F1);
        in_data_valid = 1'b0;
        check("bp_overflow_set", 64'(overflow),   64'(1));
        check("bp_tvalid_hold",  64'(axis.tvalid), 64'(1));
        check("bp_tdata_hold",   64'(axis.tdata),  64'(exp_q[0][31:0]));
        tick();
        check("bp_tdata_stable", 64'(axis.tdata),  64'(exp_q[0][31:0]));
        axis.tready = 1'b1;
        drain();
        for (int i = NACC; i < 4; i++) send_acc(12'(12'h100 + i));
        in_data_valid = 1'b0;
        drain();
        check("overflow_sticky", 64'(overflow), 64'(1));
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("overflow_cleared", 64'(overflow), 64'(0));

        // len=3, enable dropped mid-packet: packet completes, then IDLE
        send_acc(12'h201);
        send_acc(12'h202);
        enable = 1'b0;
        for (int i = 3; i <= 6; i++) send_acc(12'(12'h200 + i));
        check("idle_ready", 64'(in_data_ready), 64'(0));
        in_data       = 12'h2F0;
        in_data_valid = 1'b1;
        repeat (2) tick();
        in_data_valid = 1'b0;
        check("idle_no_overflow", 64'(overflow),      64'(0));
        check("idle_ready_held",  64'(in_data_ready), 64'(0));
        drain();
        repeat (3) tick();
        check("idle_no_output", 64'(axis.tvalid), 64'(0));

        // Reset mid-packet with a half-word pending
        packet_len_reg = 32'd2;
        enable         = 1'b1;
        tick();
        model_start();
        send_acc(12'h011);
        send_acc(12'h012);
        send_acc(12'h013);
        in_data_valid = 1'b0;
        check("pre_rst_tvalid", 64'(axis.tvalid), 64'(1));
        rst_n = 1'b0;
        tick();
        check("mid_rst_ready",    64'(in_data_ready), 64'(0));
        check("mid_rst_tvalid",   64'(axis.tvalid),   64'(0));
        check("mid_rst_tlast",    64'(axis.tlast),    64'(0));
        check("mid_rst_tdata",    64'(axis.tdata),    64'(0));
        check("mid_rst_overflow", 64'(overflow),      64'(0));
        exp_q.delete();
        model_reset();
        rst_n = 1'b1;
        tick();
        model_start();
        send_acc(12'h021);
        send_acc(12'h022);
        send_acc(12'h023);
        send_acc(12'h024);
        in_data_valid = 1'b0;
        drain();

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
